// File: rtl/sl_receiver.sv
// Receive side of the two-wire SL link: synchronizes and glitch-filters SL0/SL1,
// decodes LSB-first words with odd parity, and reports data, valid and error flags.
module sl_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TO_PHASES   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SL0,
  input  logic        SL1,
  input  logic [9:0]  wr_config_w,
  input  logic        wr_config_enable,
  output logic [9:0]  r_config_w,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun,
  output logic        rx_busy
);

  typedef enum logic [2:0] {StIdle, StPulse, StGap, StStop, StResync} state_e;

  state_e state_q, state_d;
  logic [9:0]  cfg_q;
  logic [SYNC_STAGES-1:0] sync0_q, sync1_q;
  logic [1:0]  line, acc_q, acc_d, cand_q, cand_d;
  logic [4:0]  stab_q, stab_d;
  logic        new_q;
  logic [5:0]  bc_q, bc_d;
  logic [31:0] shift_q, shift_d;
  logic        par_q, par_d;
  logic [7:0]  to_q, to_d;
  logic        busy_q, busy_d;
  logic        err_ev, done;
  logic [31:0] rx_data_q;
  logic        valid_q, perr_q, ferr_q, ovr_q;

  logic [5:0]  bq, phase;
  logic [4:0]  filt;
  logic [8:0]  limit;
  logic [31:0] mask;
  logic        is_bit, bit_v, to_hit;

  always_comb begin
    if (cfg_q[5:0] == 6'd0)       bq = 6'd1;
    else if (cfg_q[5:0] > 6'd32)  bq = 6'd32;
    else                          bq = cfg_q[5:0];
    phase = (cfg_q[9:7] <= 3'd4) ? (6'd2 << cfg_q[9:7]) : 6'd2;
    filt  = phase[5:1];
    limit = 9'(TO_PHASES * 32'(phase));
    mask  = (bq >= 6'd32) ? 32'hffff_ffff : ((32'd1 << bq) - 32'd1);
  end

  assign line = {sync0_q[SYNC_STAGES-1], sync1_q[SYNC_STAGES-1]};

  // A symbol is accepted once the synchronized pair holds the same value for filt clocks.
  always_comb begin
    acc_d  = acc_q;
    cand_d = cand_q;
    stab_d = stab_q;
    if (line == acc_q) begin
      cand_d = acc_q;
      stab_d = '0;
    end else begin
      if (line == cand_q) begin
        stab_d = stab_q + 5'd1;
      end else begin
        cand_d = line;
        stab_d = 5'd1;
      end
      if (stab_d >= filt) acc_d = line;
    end
  end

  assign is_bit = (acc_q == 2'b10) || (acc_q == 2'b01);
  assign bit_v  = (acc_q == 2'b10);
  assign to_hit = ({1'b0, to_q} + 9'd1) >= limit;

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    shift_d = shift_q;
    par_d   = par_q;
    to_d    = to_q;
    busy_d  = busy_q;
    err_ev  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        bc_d = '0;
        to_d = '0;
        if (new_q) begin
          if (is_bit) begin
            shift_d[0] = bit_v;
            bc_d       = 6'd1;
            par_d      = bit_v;
            busy_d     = 1'b1;
            state_d    = StPulse;
          end else if (acc_q == 2'b00) begin
            err_ev = 1'b1;
          end
        end
      end
      StPulse: begin
        if (new_q) begin
          if (acc_q == 2'b11) state_d = StGap;
          else                err_ev  = 1'b1;
        end
      end
      StGap: begin
        if (new_q) begin
          if (is_bit) begin
            if (bc_q < bq) begin
              shift_d[bc_q[4:0]] = bit_v;
              par_d   = par_q ^ bit_v;
              bc_d    = bc_q + 6'd1;
              state_d = StPulse;
            end else if (bc_q == bq) begin
              par_d   = par_q ^ bit_v;
              bc_d    = bc_q + 6'd1;
              state_d = StPulse;
            end else begin
              err_ev = 1'b1;
            end
          end else if ((acc_q == 2'b00) && (bc_q == bq + 6'd1)) begin
            state_d = StStop;
          end else begin
            err_ev = 1'b1;
          end
        end
      end
      StStop: begin
        if (new_q) begin
          if (acc_q == 2'b11) begin
            done    = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            err_ev = 1'b1;
          end
        end
      end
      StResync: begin
        if (acc_q != 2'b11) begin
          to_d = '0;
        end else if (to_hit) begin
          to_d    = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Inactivity watchdog while inside a frame.
    if ((state_q == StPulse) || (state_q == StGap) || (state_q == StStop)) begin
      if (new_q)       to_d   = '0;
      else if (to_hit) err_ev = 1'b1;
      else             to_d   = to_q + 8'd1;
    end
    if (err_ev) begin
      state_d = StResync;
      to_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= '1;
      sync1_q <= '1;
      acc_q   <= 2'b11;
      cand_q  <= 2'b11;
      stab_q  <= '0;
      new_q   <= 1'b0;
      state_q <= StIdle;
      bc_q    <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
      busy_q  <= 1'b0;
      cfg_q   <= 10'b0100001000;
    end else begin
      sync0_q <= {sync0_q[SYNC_STAGES-2:0], SL0};
      sync1_q <= {sync1_q[SYNC_STAGES-2:0], SL1};
      acc_q   <= acc_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      new_q   <= (acc_d != acc_q);
      state_q <= state_d;
      bc_q    <= bc_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      if ((state_q == StIdle) && wr_config_enable) cfg_q <= wr_config_w;
    end
  end

  // Completion outranks a simultaneous acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (done) begin
        rx_data_q <= shift_q & mask;
        valid_q   <= 1'b1;
        perr_q    <= ~par_q;
        ferr_q    <= 1'b0;
        if (valid_q && cfg_q[6]) ovr_q <= 1'b1;
      end else begin
        if (!cfg_q[6] || rx_ack) valid_q <= 1'b0;
        if (rx_ack) begin
          perr_q <= 1'b0;
          ovr_q  <= 1'b0;
        end
        if (err_ev)      ferr_q <= 1'b1;
        else if (rx_ack) ferr_q <= 1'b0;
      end
    end
  end

  assign r_config_w = cfg_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign rx_busy    = busy_q;

endmodule

// File: tb/tb_sl_receiver.sv
// Scoreboard bench for sl_receiver: a transmitter model queues expected words,
// a monitor checks each completed word as the receiver presents it.
`timescale 1ns/1ps
module tb_sl_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sl0, sl1;
  logic [9:0]  wr_config_w;
  logic        wr_config_enable;
  logic [9:0]  r_config_w;
  logic [31:0] rx_data;
  logic        rx_valid, rx_ack, parity_err, frame_err, overrun, rx_busy;

  sl_receiver #(.SYNC_STAGES(2), .TO_PHASES(4)) dut (
    .clk(clk), .rst_n(rst_n), .SL0(sl0), .SL1(sl1),
    .wr_config_w(wr_config_w), .wr_config_enable(wr_config_enable),
    .r_config_w(r_config_w), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        perr;
    logic        pulse;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   exp_irqm = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a word is presented when rx_valid rises or its data changes while held.
  logic        prev_v = 1'b0;
  logic [31:0] prev_d = '0;
  bit          pend = 1'b0;
  bit          pend_pulse = 1'b0;
  exp_t        mon_e;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev_v = 1'b0;
      pend   = 1'b0;
    end else begin
      if (pend) begin
        check("valid_width", 32'(rx_valid), pend_pulse ? 32'd0 : 32'd1);
        pend = 1'b0;
      end
      if (rx_valid && (!prev_v || (rx_data != prev_d))) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", rx_data, 32'hxxxx_xxxx);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data", rx_data, mon_e.d);
          check("word_flags", {30'd0, parity_err, frame_err}, {30'd0, mon_e.perr, 1'b0});
          pend       = 1'b1;
          pend_pulse = mon_e.pulse;
        end
      end
      prev_v = rx_valid;
      prev_d = rx_data;
    end
  end

  task automatic drive_sym(input logic [1:0] s, input int n);
    {sl0, sl1} = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic write_cfg(input logic [9:0] v);
    wr_config_w      = v;
    wr_config_enable = 1'b1;
    @(negedge clk);
    wr_config_enable = 1'b0;
    exp_irqm = v[6];
  endtask

  // Sends one word; flip_par sends the wrong parity, poke writes config mid-frame.
  task automatic send_word(input logic [31:0] d, input int nb, input int p,
                           input bit flip_par, input bit poke);
    logic [31:0] m;
    logic        par;
    exp_t        e;
    m      = (nb >= 32) ? 32'hffff_ffff : ((32'd1 << nb) - 32'd1);
    par    = ~(^(d & m)) ^ flip_par;
    e.d    = d & m;
    e.perr = flip_par;
    e.pulse = !exp_irqm;
    exp_q.push_back(e);
    for (int i = 0; i < nb; i++) begin
      drive_sym(d[i] ? 2'b10 : 2'b01, p);
      if (poke && i == 0) begin
        wr_config_w      = 10'h004;
        wr_config_enable = 1'b1;
        drive_sym(2'b11, 1);
        wr_config_enable = 1'b0;
        drive_sym(2'b11, p - 1);
      end else begin
        drive_sym(2'b11, p);
      end
    end
    drive_sym(par ? 2'b10 : 2'b01, p);
    drive_sym(2'b11, p);
    drive_sym(2'b00, p);
    drive_sym(2'b11, 3 * p + 6);
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; sl0 = 1'b1; sl1 = 1'b1;
    wr_config_w = '0; wr_config_enable = 1'b0; rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cfg", 32'(r_config_w), 32'h108);
    check("reset_data", rx_data, 32'h0);
    check("reset_flags", {26'd0, rx_valid, parity_err, frame_err, overrun, rx_busy, 1'b0}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Default config: 8 bits, P=8, pulse mode.
    send_word(32'hA5, 8, 8, 1'b0, 1'b0);
    send_word(32'h01, 8, 8, 1'b1, 1'b0);
    check("perr_sticky", 32'(parity_err), 32'd1);

    // 32 bits, P=2, level mode.
    write_cfg(10'h060);
    check("cfg_32b", 32'(r_config_w), 32'h060);
    send_word(32'hDEAD_BEEF, 32, 2, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("level_held", 32'(rx_valid), 32'd1);
    ack();
    check("level_acked", 32'(rx_valid), 32'd0);

    // Overrun: two words without acknowledge.
    write_cfg(10'h048);
    send_word(32'h11, 8, 2, 1'b0, 1'b0);
    send_word(32'h22, 8, 2, 1'b0, 1'b0);
    check("ovr_data", rx_data, 32'h22);
    check("ovr_set", {30'd0, rx_valid, overrun}, 32'h3);
    ack();
    check("ovr_cleared", {30'd0, rx_valid, overrun}, 32'h0);

    // P=16: glitch rejection, truncated frame, timeout and resync.
    write_cfg(10'h184);
    check("cfg_p16", 32'(r_config_w), 32'h184);
    drive_sym(2'b10, 5);
    drive_sym(2'b11, 20);
    check("glitch_idle", {30'd0, rx_busy, frame_err}, 32'h0);
    drive_sym(2'b10, 16);
    drive_sym(2'b11, 16);
    drive_sym(2'b10, 16);
    drive_sym(2'b11, 90);
    check("timeout_ferr", {30'd0, rx_busy, frame_err}, 32'h3);
    drive_sym(2'b11, 80);
    check("resync_idle", {30'd0, rx_busy, frame_err}, 32'h1);
    send_word(32'h9, 4, 16, 1'b0, 1'b0);

    // Config write mid-frame is dropped; in idle it lands next cycle.
    send_word(32'h3, 4, 16, 1'b0, 1'b1);
    check("cfg_midframe", 32'(r_config_w), 32'h184);
    write_cfg(10'h004);
    check("cfg_idle", 32'(r_config_w), 32'h004);
    send_word(32'h9, 4, 2, 1'b0, 1'b0);

    // Asynchronous reset mid-frame.
    drive_sym(2'b10, 6);
    check("busy_mid", 32'(rx_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(rx_busy), 32'd0);
    check("async_rst_cfg", 32'(r_config_w), 32'h108);
    {sl0, sl1} = 2'b11;
    exp_irqm = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_word(32'h3C, 8, 8, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sl_receiver.md
Name: sl_receiver

Overview:
- Receive side of the two-wire SL link. Consumes the SL0/SL1 pair driven by the SL transmitter and decodes each word.
- Word format: LSB-first data bits, one odd-parity bit, a stop symbol, then return to idle.
- Presents the decoded word, a valid flag and error flags to the master. Uses the same 10-bit configuration word layout as the transmitter, so both ends are programmed identically.

Parameters:
- SYNC_STAGES, 2, input synchronizer depth on SL0/SL1 (minimum 2).
- TO_PHASES, 4, inactivity timeout in line phases.

Ports:
- clk  in  1  system clock, 16 MHz
- rst_n  in  1  asynchronous reset, active-low
- SL0  in  1  serial line 0, idle high
- SL1  in  1  serial line 1, idle high
- wr_config_w  in  10  config write value
- wr_config_enable  in  1  config write strobe
- r_config_w  out  10  current config
- rx_data  out  32  last received word, zero-extended above bit quantity
- rx_valid  out  1  word available
- rx_ack  in  1  master acknowledge, clears rx_valid and error flags
- parity_err  out  1  parity check failed on the presented word
- frame_err  out  1  illegal symbol sequence, length mismatch or timeout
- overrun  out  1  word completed while rx_valid still set (IRQM=1)
- rx_busy  out  1  frame reception in progress

Behaviour:
- Reset values: config = 10'b0100001000 (8 bits, IRQM=0, 2 MHz). rx_data = 0. rx_valid, parity_err, frame_err, overrun, rx_busy = 0. Synchronizer flops = 1. FSM = IDLE.
- Config fields:
  - [5:0] BQ: data bit count, 1..32; 0 is treated as 1, values above 32 as 32.
  - [6] IRQM: 0 = rx_valid is a 1-cycle pulse; 1 = rx_valid is a level held until rx_ack.
  - [9:7] FQ: 0..4 give phase length P = 2, 4, 8, 16, 32 clk; 5..7 give P = 2.
- Config write: accepted only when FSM is IDLE and wr_config_enable=1, taking effect the next cycle. Writes in any other state are dropped.
- Glitch filter:
  - A synchronized {SL0,SL1} pair becomes the accepted symbol only after it has been stable for F = P/2 consecutive clk.
  - Symbols: 11 gap/idle, 10 ONE, 01 ZERO, 00 STOP.
  - FSM acts only on accepted-symbol changes.
- FSM states: IDLE, PULSE, GAP, STOP, RESYNC. The bit counter bc is 6 bits and is cleared in IDLE.
  - IDLE:
    - ONE/ZERO: store the bit at rx_shift[0], set bc=1, clear parity accumulator, then count 1 if ONE; go to PULSE and set rx_busy=1.
    - STOP: frame_err, go to RESYNC.
  - PULSE:
    - 11: go to GAP.
    - Any other symbol: frame_err, go to RESYNC.
  - GAP:
    - ONE/ZERO with bc<BQ: store the bit at rx_shift[bc], bc++, go to PULSE.
    - ONE/ZERO with bc==BQ: this is the parity bit; accumulate, bc++, go to PULSE.
    - ONE/ZERO with bc>BQ: frame_err, go to RESYNC.
    - STOP with bc==BQ+1: go to STOP.
    - STOP with any other bc: frame_err, go to RESYNC.
  - STOP:
    - 11: word complete, go to IDLE and clear rx_busy.
    - Any other symbol: frame_err, go to RESYNC.
  - RESYNC:
    - Accepted symbol 11 held for TO_PHASES*P clk: go to IDLE and clear rx_busy.
    - Any non-11 symbol restarts the count.
- Timeout: in PULSE, GAP or STOP, if no accepted-symbol change occurs for TO_PHASES*P clk (8-bit counter, maximum 128), raise frame_err and go to RESYNC.
- Word completion, in the cycle after STOP→11 is accepted:
  - rx_data <= rx_shift with bits ≥BQ forced to 0.
  - rx_valid <= 1.
  - parity_err <= 1 if the ONE count (data + parity bit) is even. Odd parity is required.
  - rx_data is updated even when parity fails.
- Latency: an SL pin edge reaches the accepted symbol after SYNC_STAGES+F clk. rx_valid rises 1 clk after the final 11 symbol is accepted.
- rx_valid and error flags:
  - IRQM=0: rx_valid high for exactly 1 cycle. parity_err/frame_err stay set until rx_ack or the next word completion.
  - IRQM=1: rx_valid held until rx_ack. rx_ack clears rx_valid, parity_err, frame_err and overrun.
  - A completion and rx_ack in the same cycle: the completion wins, so rx_valid stays 1 with the new data.
  - A completion while rx_valid=1 (IRQM=1): rx_data is overwritten and overrun=1 (sticky).
- frame_err is sticky until rx_ack and does not assert rx_valid.
- Asynchronous reset mid-frame: all state returns to reset values immediately and the partial word is discarded.

Test Plan:
- Default config, transmitter sends 0xA5 → rx_data=0x000000A5, rx_valid pulse 1 clk, parity_err=0, frame_err=0.
- FQ=0, BQ=32, IRQM=1, word 0xDEADBEEF → rx_data=0xDEADBEEF, rx_valid held until rx_ack, then 0.
- 8-bit 0x01 with the parity pulse forced to ONE (even total) → rx_data=0x01, rx_valid=1, parity_err=1.
- FQ=3 (P=16), inject 5-clk low glitch on SL1 while idle → no state change, rx_busy=0. Then a 4-bit frame of 0xF truncated after bit 2 → frame_err=1 after 64 clk of inactivity, RESYNC, subsequent valid frame received correctly.
- IRQM=1, two back-to-back words 0x11 then 0x22 without rx_ack → rx_data=0x22, overrun=1. rx_ack clears rx_valid and overrun.
- wr_config_enable with 10'b0000000100 asserted mid-frame → r_config_w unchanged. Repeated in IDLE → r_config_w=0x004 next cycle, 4-bit frame 0x9 → rx_data=0x9.
